// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: multi-cycle mult/multu/div/divu, single-cycle mthi/mtlo.
// Optional multiply-accumulate (madd/msub) enabled by defining MDU_MADD_EN.
module mdu_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 div_sgn_s;
    logic [WIDTH:0]       rem_sh_s;
    logic [WIDTH:0]       trial_s;
    logic [WIDTH-1:0]     rem_nxt_s;
    logic [WIDTH-1:0]     quo_nxt_s;
    logic [WIDTH-1:0]     quo_fin_s;
    logic [WIDTH-1:0]     rem_fin_s;
    logic                 mul_sgn_s;
    logic [2*WIDTH-1:0]   ext_a_s;
    logic [2*WIDTH-1:0]   ext_b_s;
    logic [2*WIDTH-1:0]   prod_s;
    logic [2*WIDTH-1:0]   mul_res_s;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Restoring divide step on magnitudes: quo_q shifts the dividend out while collecting quotient bits.
    always_comb begin
        rem_sh_s  = {rem_q, quo_q[WIDTH-1]};
        trial_s   = rem_sh_s - {1'b0, b_q};
        if (!trial_s[WIDTH]) begin
            rem_nxt_s = trial_s[WIDTH-1:0];
            quo_nxt_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = rem_sh_s[WIDTH-1:0];
            quo_nxt_s = {quo_q[WIDTH-2:0], 1'b0};
        end
        quo_fin_s = quo_neg_q ? -quo_nxt_s : quo_nxt_s;
        rem_fin_s = rem_neg_q ? -rem_nxt_s : rem_nxt_s;
    end

    // Full-width product of the latched operands, optionally folded into the current {hi,lo}.
    always_comb begin
        mul_sgn_s = (op_q != OP_MULTU);
        ext_a_s   = mul_sgn_s ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b_s   = mul_sgn_s ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod_s    = ext_a_s * ext_b_s;
`ifdef MDU_MADD_EN
        if (op_q == OP_MADD) begin
            mul_res_s = {hi_q, lo_q} + prod_s;
        end else if (op_q == OP_MSUB) begin
            mul_res_s = {hi_q, lo_q} - prod_s;
        end else begin
            mul_res_s = prod_s;
        end
`else
        mul_res_s = prod_s;
`endif
    end

    // Next-state logic: launch from IDLE, count down, commit result to hi/lo on the last busy cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        div_sgn_s = (op == OP_DIV);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
`ifdef MDU_MADD_EN
                        OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: begin
`else
                        OP_MULT, OP_MULTU: begin
`endif
                            state_d = S_MUL;
                            cnt_d   = MUL_LOAD;
                            busy_d  = 1'b1;
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = S_DIV;
                            cnt_d     = DIV_LOAD;
                            busy_d    = 1'b1;
                            op_d      = op;
                            a_d       = a;
                            b_d       = magnitude(b, div_sgn_s);
                            quo_d     = magnitude(a, div_sgn_s);
                            rem_d     = {WIDTH{1'b0}};
                            quo_neg_d = div_sgn_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg_d = div_sgn_s & a[WIDTH-1];
                            div0_d    = (b == {WIDTH{1'b0}});
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_ZERO) begin
                    {hi_d, lo_d} = mul_res_s;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DIV: begin
                rem_d = rem_nxt_s;
                quo_d = quo_nxt_s;
                if (cnt_q == CNT_ZERO) begin
                    if (div0_q) begin
                        lo_d = {WIDTH{1'b1}};
                        hi_d = a_q;
                    end else begin
                        lo_d = quo_fin_s;
                        hi_d = rem_fin_s;
                    end
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any op in flight and clears HI/LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            op_q      <= 3'b000;
            a_q       <= {WIDTH{1'b0}};
            b_q       <= {WIDTH{1'b0}};
            rem_q     <= {WIDTH{1'b0}};
            quo_q     <= {WIDTH{1'b0}};
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=32).
module tb_mdu_iter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    mdu_iter #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with the unit idle; returns at the negedge where busy has dropped.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int exp_cyc);
        int cyc;
        int ndone;
        logic stable;
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
        check_eq({tag, "/done_low"}, {63'd0, done}, 64'd0);
        cyc = 0;
        ndone = 0;
        stable = 1'b1;
        while (busy && cyc < 200) begin
            cyc++;
            if (done) ndone++;
            if (hi !== h0 || lo !== l0) stable = 1'b0;
            @(negedge clk);
        end
        check_eq({tag, "/cycles"}, 64'(cyc), 64'(exp_cyc));
        check_eq({tag, "/done"}, {63'd0, done}, {63'd0, exp_cyc > 0});
        if (exp_cyc > 0) begin
            check_eq({tag, "/hold"}, {63'd0, stable}, 64'd1);
            check_eq({tag, "/early_done"}, 64'(ndone), 64'd0);
        end
    endtask

    initial begin
        int cyc;
        reset_n = 1'b0;
        start = 1'b0;
        op = 3'b000;
        a = 32'd0;
        b = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("rst/state", {30'd0, busy, done, hi}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst/lo", {32'd0, lo}, 64'd0);

        do_op("mthi", 3'b100, 32'h0000_AAAA, 32'd0, 0);
        do_op("mtlo", 3'b101, 32'h0000_5555, 32'd0, 0);
        check_eq("mtx", {hi, lo}, 64'h0000_AAAA_0000_5555);

        // Reset while a divide is at cnt=10.
        start = 1'b1;
        op = 3'b010;
        a = 32'd100;
        b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (21) @(negedge clk);
        check_eq("mid/busy", {63'd0, busy}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid/rst_flags", {62'd0, busy, done}, 64'd0);
        check_eq("mid/rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("mid/after_flags", {62'd0, busy, done}, 64'd0);
        check_eq("mid/after_hilo", {hi, lo}, 64'd0);

        // Results chained back-to-back: each op starts on the cycle busy falls.
        do_op("mult", 3'b000, 32'hFFFF_FFFD, 32'd7, 5);
        check_eq("mult/res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 32);
        check_eq("div/res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("divu", 3'b011, 32'd7, 32'd2, 32);
        check_eq("divu/res", {hi, lo}, 64'h0000_0001_0000_0003);
        do_op("div_pn", 3'b010, 32'd7, 32'hFFFF_FFFE, 32);
        check_eq("div_pn/res", {hi, lo}, 64'h0000_0001_FFFF_FFFD);
        do_op("divu_big", 3'b011, 32'hFFFF_FFF9, 32'd2, 32);
        check_eq("divu_big/res", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
        do_op("div0", 3'b010, 32'd5, 32'd0, 32);
        check_eq("div0/res", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
        do_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32);
        check_eq("div_ovf/res", {hi, lo}, 64'h0000_0000_8000_0000);
        do_op("mult_m1", 3'b000, 32'hFFFF_FFFF, 32'd2, 5);
        check_eq("mult_m1/res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op("multu_m1", 3'b001, 32'hFFFF_FFFF, 32'd2, 5);
        check_eq("multu_m1/res", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        // mthi issued while busy must be ignored.
        start = 1'b1;
        op = 3'b001;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        @(negedge clk);
        op = 3'b100;
        a = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check_eq("multu_ign/cycles", 64'(cyc), 64'd6);
        check_eq("multu_ign/res", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_op("mthi2", 3'b100, 32'h0000_1234, 32'd0, 0);
        check_eq("mthi2/res", {hi, lo}, 64'h0000_1234_0000_0001);

`ifdef MDU_MADD_EN
        do_op("ld_hi", 3'b100, 32'h0000_0000, 32'd0, 0);
        do_op("ld_lo", 3'b101, 32'h0000_0010, 32'd0, 0);
        do_op("madd", 3'b110, 32'd2, 32'd3, 5);
        check_eq("madd/res", {hi, lo}, 64'h0000_0000_0000_0016);
        do_op("msub", 3'b111, 32'd4, 32'd5, 5);
        check_eq("msub/res", {hi, lo}, 64'h0000_0000_0000_0002);
        do_op("msub_wrap", 3'b111, 32'd4, 32'd5, 5);
        check_eq("msub_wrap/res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEE);
`else
        do_op("op110", 3'b110, 32'd2, 32'd3, 0);
        check_eq("op110/res", {hi, lo}, 64'h0000_1234_0000_0001);
        do_op("op111", 3'b111, 32'd4, 32'd5, 0);
        check_eq("op111/res", {hi, lo}, 64'h0000_1234_0000_0001);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
